// File: rtl/fir_qmn_mac.sv
// Fixed-point Qm.n FIR filter built around one time-multiplexed multiply-accumulate unit.
// Each accepted sample shifts the delay line. The block then spends NTAPS cycles
// accumulating d[k]*c[k] and one cycle rounding and saturating the result into y_out.
// Coefficients can be loaded at runtime. A write only lands while the block is idle.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   x_in carries a new sample
//   in_ready   block accepts a sample this cycle (idle)
//   x_in       signed Qm.n input sample
//   out_valid  one-cycle pulse, y_out holds a new result
//   y_out      signed Qm.n filtered output, held until the next result
//   coef_we    coefficient write strobe (honoured in idle only)
//   coef_addr  tap index for the write (indices >= NTAPS ignored)
//   coef_data  signed Qm.n coefficient value
module fir_qmn_mac #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned NTAPS  = 8,
  localparam int unsigned AW    = $clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y_out,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + AW;
  // Half an LSB of the output, used for round-half-up.
  localparam logic [ACC_W:0] RND = (ACC_W + 1)'(1) << (FRAC_W - 1);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e state_q, state_d;

  logic signed [DATA_W-1:0] dline_q [NTAPS];
  logic signed [COEF_W-1:0] coef_q  [NTAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]            idx_q, idx_d;

  logic                     accept;
  logic                     coef_wr;
  logic                     last_tap;
  logic [DATA_W-1:0]        d_sel;
  logic [COEF_W-1:0]        c_sel;
  logic [PROD_W-1:0]        prod;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    rnd_shift;
  logic [ACC_W-DATA_W+1:0]  rnd_upper;
  logic signed [DATA_W-1:0] y_sat;

  assign accept   = in_valid && (state_q == StIdle);
  assign coef_wr  = coef_we && (state_q == StIdle) && (32'(coef_addr) < NTAPS);
  assign last_tap = (idx_q == AW'(NTAPS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StMac;
      StMac:   if (last_tap) state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = (state_q == StIdle);
  end

  // Multiply-accumulate. Operands are sign-extended to the product width. The low PROD_W
  // bits of the unsigned product are then the exact signed product.
  always_comb begin
    d_sel = dline_q[idx_q];
    c_sel = coef_q[idx_q];
    prod  = {{COEF_W{d_sel[DATA_W-1]}}, d_sel} * {{DATA_W{c_sel[COEF_W-1]}}, c_sel};
    acc_d = acc_q;
    idx_d = idx_q;
    if (accept) begin
      acc_d = '0;
      idx_d = '0;
    end else if (state_q == StMac) begin
      acc_d = acc_q + {{AW{prod[PROD_W-1]}}, prod};
      idx_d = idx_q + AW'(1);
    end
  end

  // Round half up, then saturate. rnd_sum has one guard bit, so adding RND cannot wrap.
  always_comb begin
    rnd_sum   = {acc_q[ACC_W-1], acc_q} + RND;
    rnd_shift = rnd_sum >>> FRAC_W;
    rnd_upper = rnd_shift[ACC_W:DATA_W-1];
    if (rnd_upper == '0 || rnd_upper == '1) begin
      y_sat = rnd_shift[DATA_W-1:0];
    end else if (rnd_shift[ACC_W]) begin
      y_sat = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      y_sat = {1'b0, {(DATA_W - 1){1'b1}}};
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        dline_q[k] <= '0;
        coef_q[k]  <= '0;
      end
      acc_q     <= '0;
      idx_q     <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      out_valid <= (state_q == StOut);
      if (state_q == StOut) begin
        y_out <= y_sat;
      end
      if (accept) begin
        dline_q[0] <= x_in;
        for (int unsigned k = 1; k < NTAPS; k++) begin
          dline_q[k] <= dline_q[k-1];
        end
      end
      if (coef_wr) begin
        coef_q[coef_addr] <= coef_data;
      end
    end
  end

endmodule
